// File: rtl/shiftout_arbiter.sv
// shiftout_arbiter: round-robin share of one 74HC595-style shift-out chain
// between two requesters. A word is accepted on valid/ready, shifted out
// MSB-first on a divided serial clock, then the storage latch is pulsed.
module shiftout_arbiter #(
  parameter int WIDTH        = 8,
  parameter int CLK_DIV      = 2,
  parameter int LATCH_CYCLES = 2
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             busy,
  output logic             last_grant,
  output logic             shiftout_clock,
  output logic             shiftout_data,
  output logic             shiftout_latch
);

  // One phase counter serves both the half-period and the latch hold time.
  localparam int CNT_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = $clog2(WIDTH);

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLK_LO, CLK_HI, LATCH} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    hcnt;
  logic             sel;
  logic             accept;

  assign shiftout_data = shift_reg[WIDTH-1];

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  // Readies are suppressed during reset so nothing is handed off into a reset.
  always_comb begin
    sel        = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
    accept     = (state == IDLE) && !reset && (req0_valid || req1_valid);
    req0_ready = accept && !sel;
    req1_ready = accept &&  sel;
  end

  // Frame sequencer: load, shift WIDTH bits on the divided clock, then latch.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state          <= IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      hcnt           <= '0;
      last_grant     <= 1'b1;
      busy           <= 1'b0;
      shiftout_clock <= 1'b0;
      shiftout_latch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg  <= sel ? req1_data : req0_data;
            last_grant <= sel;
            bit_cnt    <= '0;
            hcnt       <= '0;
            busy       <= 1'b1;
            state      <= CLK_LO;
          end
        end
        CLK_LO: begin
          if (hcnt == DIV_LAST) begin
            hcnt           <= '0;
            shiftout_clock <= 1'b1;
            state          <= CLK_HI;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        CLK_HI: begin
          if (hcnt == DIV_LAST) begin
            hcnt           <= '0;
            shiftout_clock <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              shiftout_latch <= 1'b1;
              state          <= LATCH;
            end else begin
              // Data moves only on the falling serial edge: full half period of setup.
              shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
              bit_cnt   <= bit_cnt + 1'b1;
              state     <= CLK_LO;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        LATCH: begin
          if (hcnt == LAT_LAST) begin
            hcnt           <= '0;
            shiftout_latch <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftout_arbiter.sv
// Bench for shiftout_arbiter: a default 8-bit instance plus a 16-bit,
// CLK_DIV=1, LATCH_CYCLES=1 instance. Monitors rebuild frames from the pins.
module tb_shiftout_arbiter;
  logic clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  int errors = 0;
  int checks = 0;

  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, busy, last_grant, so_clk, so_dat, so_lat;

  shiftout_arbiter dut (
    .clk_25MHz(clk_25MHz), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .busy(busy), .last_grant(last_grant),
    .shiftout_clock(so_clk), .shiftout_data(so_dat), .shiftout_latch(so_lat)
  );

  logic        b_v0 = 1'b0, b_v1 = 1'b0;
  logic [15:0] b_d0 = '0, b_d1 = '0;
  logic        b_r0, b_r1, b_busy, b_lg, b_clk, b_dat, b_lat;

  shiftout_arbiter #(.WIDTH(16), .CLK_DIV(1), .LATCH_CYCLES(1)) dut_b (
    .clk_25MHz(clk_25MHz), .reset(reset),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .busy(b_busy), .last_grant(b_lg),
    .shiftout_clock(b_clk), .shiftout_data(b_dat), .shiftout_latch(b_lat)
  );

  typedef struct {int idx; logic [15:0] data; int cyc; logic v0; logic v1;} acc_t;
  typedef struct {logic [15:0] word; int nbits; int lat;} frm_t;

  // ---- monitor, default instance ----
  acc_t        accq[$];
  frm_t        frmq[$];
  int          cyc = 0, proto_err = 0, nb = 0, ll = 0;
  logic [15:0] cur = '0;
  logic        prev_clk = 1'b0, prev_lat = 1'b0;

  always @(negedge clk_25MHz) begin
    cyc++;
    if (reset) begin
      cur = '0; nb = 0; ll = 0; prev_clk = 1'b0; prev_lat = 1'b0;
    end else begin
      if (req0_ready && req1_ready) proto_err++;
      if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid)) proto_err++;
      if (busy && (req0_ready || req1_ready)) proto_err++;
      if (so_clk && so_lat) proto_err++;
      if (req0_valid && req0_ready) accq.push_back('{0, {8'h00, req0_data}, cyc, req0_valid, req1_valid});
      if (req1_valid && req1_ready) accq.push_back('{1, {8'h00, req1_data}, cyc, req0_valid, req1_valid});
      if (so_clk && !prev_clk) begin cur = {cur[14:0], so_dat}; nb++; end
      if (so_lat) ll++;
      if (!so_lat && prev_lat) begin frmq.push_back('{cur, nb, ll}); cur = '0; nb = 0; ll = 0; end
      prev_clk = so_clk; prev_lat = so_lat;
    end
  end

  // ---- monitor, wide instance ----
  int          baccq[$];
  frm_t        bfrmq[$];
  int          bnb = 0, bll = 0;
  logic [15:0] bcur = '0;
  logic        bprev_clk = 1'b0, bprev_lat = 1'b0;

  always @(negedge clk_25MHz) begin
    if (reset) begin
      bcur = '0; bnb = 0; bll = 0; bprev_clk = 1'b0; bprev_lat = 1'b0;
    end else begin
      if (b_v0 && b_r0) baccq.push_back(cyc);
      if (b_clk && !bprev_clk) begin bcur = {bcur[14:0], b_dat}; bnb++; end
      if (b_lat) bll++;
      if (!b_lat && bprev_lat) begin bfrmq.push_back('{bcur, bnb, bll}); bcur = '0; bnb = 0; bll = 0; end
      bprev_clk = b_clk; bprev_lat = b_lat;
    end
  end

  task automatic tick;
    @(posedge clk_25MHz); #1;
  endtask

  task automatic clear_mon;
    accq.delete(); frmq.delete(); baccq.delete(); bfrmq.delete(); proto_err = 0;
  endtask

  task automatic pulse_reset;
    req0_valid = 1'b0; req1_valid = 1'b0; b_v0 = 1'b0;
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic wait_acc(input int n, input string nm);
    int k = 0;
    while (accq.size() < n && k < 300) begin tick(); k++; end
    checks++;
    if (accq.size() < n) begin
      errors++; $display("FAIL %s accept timeout: got %0d want %0d", nm, accq.size(), n);
    end
  endtask

  task automatic wait_frm(input int n, input string nm);
    int k = 0;
    while (frmq.size() < n && k < 300) begin tick(); k++; end
    checks++;
    if (frmq.size() < n) begin
      errors++; $display("FAIL %s frame timeout: got %0d want %0d", nm, frmq.size(), n);
    end
  endtask

  // Frame i must carry the accepted word, WIDTH rising edges and the latch length.
  task automatic check_frame(input int i, input logic [15:0] exp, input string nm);
    checks++;
    if (frmq[i].word !== exp) begin errors++; $display("FAIL %s frame%0d word got %h want %h", nm, i, frmq[i].word, exp); end
    checks++;
    if (frmq[i].nbits !== 8) begin errors++; $display("FAIL %s frame%0d edges got %0d want 8", nm, i, frmq[i].nbits); end
    checks++;
    if (frmq[i].lat !== 2) begin errors++; $display("FAIL %s frame%0d latch got %0d want 2", nm, i, frmq[i].lat); end
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(); tick(); tick();
    reset = 1'b0; tick();
    checks++;
    if ({busy, so_clk, so_dat, so_lat, req0_ready, req1_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 000000", {busy, so_clk, so_dat, so_lat, req0_ready, req1_ready});
    end
    checks++;
    if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant got %b want 1", last_grant); end
    checks++;
    if ({b_busy, b_clk, b_dat, b_lat, b_lg} !== 5'b00001) begin
      errors++; $display("FAIL reset_wide got %b want 00001", {b_busy, b_clk, b_dat, b_lat, b_lg});
    end
    clear_mon();
  endtask

  task automatic test_single;
    req0_valid = 1'b1; req0_data = 8'hA5;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
    wait_acc(2, "single");
    req0_valid = 1'b0;
    wait_frm(2, "single");
    checks++;
    if (accq[1].cyc - accq[0].cyc !== 35) begin
      errors++; $display("FAIL single_spacing got %0d want 35", accq[1].cyc - accq[0].cyc);
    end
    check_frame(0, 16'h00A5, "single");
    check_frame(1, 16'h00A5, "single");
  endtask

  task automatic test_alternate;
    logic lg;
    int   exp_idx;
    pulse_reset();
    req0_valid = 1'b1; req0_data = 8'h01;
    req1_valid = 1'b1; req1_data = 8'h80;
    wait_acc(4, "alternate");
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_frm(4, "alternate");
    lg = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_idx = lg ? 0 : 1;
      lg = ~lg;
      checks++;
      if (accq[i].idx !== exp_idx) begin errors++; $display("FAIL alternate_grant%0d got %0d want %0d", i, accq[i].idx, exp_idx); end
      check_frame(i, exp_idx == 1 ? 16'h0080 : 16'h0001, "alternate");
    end
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL alternate_protocol got %0d violations want 0", proto_err); end
  endtask

  task automatic test_only_req1;
    logic [7:0] sent[4];
    int seen = 0;
    clear_mon();
    req1_valid = 1'b1; req1_data = 8'($urandom); sent[0] = req1_data;
    for (int k = 0; k < 400 && accq.size() < 3; k++) begin
      tick();
      if (accq.size() > seen) begin
        seen++;
        req1_data = 8'($urandom);
        if (seen < 4) sent[seen] = req1_data;
      end
    end
    req0_valid = 1'b1; req0_data = 8'h3C; sent[3] = 8'h3C;
    wait_acc(4, "only_req1");
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_frm(4, "only_req1");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (accq[i].idx !== (i < 3 ? 1 : 0)) begin errors++; $display("FAIL only_req1_grant%0d got %0d want %0d", i, accq[i].idx, i < 3 ? 1 : 0); end
      check_frame(i, {8'h00, sent[i]}, "only_req1");
    end
    checks++;
    if (accq[2].cyc - accq[1].cyc !== 35) begin errors++; $display("FAIL only_req1_spacing got %0d want 35", accq[2].cyc - accq[1].cyc); end
  endtask

  task automatic test_data_hold;
    logic [7:0] w;
    clear_mon();
    w = 8'($urandom);
    req0_valid = 1'b1; req0_data = w;
    wait_acc(1, "data_hold");
    req0_data = ~w; req0_valid = 1'b0;
    wait_frm(1, "data_hold");
    check_frame(0, {8'h00, w}, "data_hold");
  endtask

  task automatic test_reset_mid;
    int k = 0, lat_seen = 0;
    logic [7:0] w;
    clear_mon();
    req0_valid = 1'b1; req0_data = 8'hFF;
    wait_acc(1, "reset_mid");
    req0_valid = 1'b0;
    while (nb < 5 && k < 200) begin @(negedge clk_25MHz); k++; end
    checks++;
    if (!(nb == 5 && so_clk === 1'b1)) begin errors++; $display("FAIL reset_mid_reach got edges=%0d clk=%b want 5,1", nb, so_clk); end
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, so_clk, so_dat, so_lat, req0_ready, req1_ready, last_grant} !== 7'b0000001) begin
      errors++; $display("FAIL reset_mid_state got %b want 0000001", {busy, so_clk, so_dat, so_lat, req0_ready, req1_ready, last_grant});
    end
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin tick(); if (so_lat) lat_seen++; end
    checks++;
    if (lat_seen !== 0 || frmq.size() !== 0) begin
      errors++; $display("FAIL reset_mid_no_latch got latch=%0d frames=%0d want 0,0", lat_seen, frmq.size());
    end
    clear_mon();
    w = 8'($urandom);
    req1_valid = 1'b1; req1_data = w;
    wait_acc(1, "reset_mid_new");
    req1_valid = 1'b0;
    wait_frm(1, "reset_mid_new");
    check_frame(0, {8'h00, w}, "reset_mid_new");
  endtask

  // Random traffic against a round-robin reference: per accept, the winner is
  // the lone valid requester, or the one not served last when both are valid.
  task automatic test_random;
    int   seen = 0, exp_idx;
    logic lg;
    pulse_reset();
    for (int c = 0; c < 1500; c++) begin
      tick();
      while (seen < accq.size()) begin
        if (accq[seen].idx == 0) begin
          if ($urandom_range(1) == 1) req0_valid = 1'b0; else req0_data = 8'($urandom);
        end else begin
          if ($urandom_range(1) == 1) req1_valid = 1'b0; else req1_data = 8'($urandom);
        end
        seen++;
      end
      if (!req0_valid && $urandom_range(3) == 0) begin req0_valid = 1'b1; req0_data = 8'($urandom); end
      else if (req0_valid && $urandom_range(40) == 0) req0_valid = 1'b0;
      if (!req1_valid && $urandom_range(3) == 0) begin req1_valid = 1'b1; req1_data = 8'($urandom); end
      else if (req1_valid && $urandom_range(40) == 0) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_frm(accq.size(), "random");
    checks++;
    if (accq.size() < 20) begin errors++; $display("FAIL random_traffic got %0d accepts want >=20", accq.size()); end
    lg = 1'b1;
    for (int i = 0; i < accq.size(); i++) begin
      exp_idx = (accq[i].v0 && accq[i].v1) ? (lg ? 0 : 1) : (accq[i].v0 ? 0 : 1);
      lg = (exp_idx == 1);
      checks++;
      if (accq[i].idx !== exp_idx) begin errors++; $display("FAIL random_grant%0d got %0d want %0d", i, accq[i].idx, exp_idx); end
      check_frame(i, accq[i].data, "random");
      if (i > 0) begin
        checks++;
        if (accq[i].cyc - accq[i-1].cyc < 35) begin
          errors++; $display("FAIL random_spacing%0d got %0d want >=35", i, accq[i].cyc - accq[i-1].cyc);
        end
      end
    end
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL random_protocol got %0d violations want 0", proto_err); end
  endtask

  task automatic test_wide;
    logic [15:0] x, y;
    int k = 0;
    clear_mon();
    x = 16'($urandom); y = 16'($urandom);
    b_v0 = 1'b1; b_d0 = x;
    while (baccq.size() < 1 && k < 200) begin tick(); k++; end
    b_d0 = y;
    while (baccq.size() < 2 && k < 400) begin tick(); k++; end
    b_v0 = 1'b0;
    while (bfrmq.size() < 2 && k < 600) begin tick(); k++; end
    checks++;
    if (bfrmq.size() !== 2) begin errors++; $display("FAIL wide_frames got %0d want 2", bfrmq.size()); end
    checks++;
    if (baccq[1] - baccq[0] !== 34) begin errors++; $display("FAIL wide_spacing got %0d want 34", baccq[1] - baccq[0]); end
    checks++;
    if (bfrmq[0].word !== x || bfrmq[1].word !== y) begin
      errors++; $display("FAIL wide_words got %h,%h want %h,%h", bfrmq[0].word, bfrmq[1].word, x, y);
    end
    checks++;
    if (bfrmq[0].nbits !== 16 || bfrmq[0].lat !== 1) begin
      errors++; $display("FAIL wide_shape got edges=%0d latch=%0d want 16,1", bfrmq[0].nbits, bfrmq[0].lat);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_only_req1();
    test_data_hold();
    test_reset_mid();
    test_random();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
